int_adder_tree_layer: RTL and testbench

One reduction layer of the integer adder tree: sums adjacent pairs of input words, halving the word count (rounded up). Layers are chained by the parent adder tree, with each layer's outputs feeding the next layer's inputs. The layer supports signed or unsigned operand extension, an optional carry-split pipeline register and an optional output register. A single side-band bit travels through the layer with the same latency as the data.

---
 rtl/int_adder_tree_layer.sv | 131 +++++++++++++
 tb/tb_int_adder_tree_layer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/int_adder_tree_layer.sv
// One layer of an integer adder tree: sums adjacent word pairs, with an optional
// carry-split middle register, an optional output register and a side-band bit.
module int_adder_tree_layer #(
  parameter int unsigned NUM_IN_WORDS        = 4,
  parameter int unsigned BITS_PER_IN_WORD    = 8,
  parameter int unsigned BITS_PER_OUT_WORD   = 9,
  parameter bit          SIGN_EXT            = 1'b1,
  parameter bit          REGISTER_MIDDLE     = 1'b0,
  parameter bit          REGISTER_OUTPUT     = 1'b0,
  parameter bit          EXTRA_BIT_CONNECTED = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BITS_PER_IN_WORD-1:0]  words_in  [NUM_IN_WORDS],
  output logic [BITS_PER_OUT_WORD-1:0] words_out [(NUM_IN_WORDS+1)/2],
  input  logic                         extra_bit_in,
  output logic                         extra_bit_out
);

  localparam int unsigned NUM_OUT_WORDS = (NUM_IN_WORDS + 1) / 2;
  localparam int unsigned NUM_PAIRS     = NUM_IN_WORDS / 2;
  localparam int unsigned IN_W          = BITS_PER_IN_WORD;
  localparam int unsigned OUT_W         = BITS_PER_OUT_WORD;
  localparam int unsigned LO_W          = OUT_W / 2;
  localparam int unsigned HI_W          = OUT_W - LO_W;

  if (BITS_PER_OUT_WORD < BITS_PER_IN_WORD + 1) begin : g_bad_width
    $error("BITS_PER_OUT_WORD must be at least BITS_PER_IN_WORD+1");
  end
  if (NUM_IN_WORDS < 1) begin : g_bad_count
    $error("NUM_IN_WORDS must be at least 1");
  end

  logic [OUT_W-1:0] ext_words [NUM_IN_WORDS];
  logic [OUT_W-1:0] mid_words [NUM_OUT_WORDS];
  logic             extra_src;
  logic             mid_extra;
  logic             unused_ok;

  assign extra_src = EXTRA_BIT_CONNECTED ? extra_bit_in : 1'b0;
  assign unused_ok = ^{clk, rst, extra_bit_in};

  // Operand extension to the output width
  for (genvar i = 0; i < NUM_IN_WORDS; i++) begin : g_ext
    if (SIGN_EXT) begin : g_sign
      assign ext_words[i] = {{(OUT_W-IN_W){words_in[i][IN_W-1]}}, words_in[i]};
    end else begin : g_zero
      assign ext_words[i] = {{(OUT_W-IN_W){1'b0}}, words_in[i]};
    end
  end

  // Pair adders, optionally split at bit LO_W with the carry registered
  for (genvar k = 0; k < NUM_PAIRS; k++) begin : g_pair
    logic [OUT_W-1:0] a;
    logic [OUT_W-1:0] b;
    assign a = ext_words[2*k];
    assign b = ext_words[2*k+1];

    if (REGISTER_MIDDLE) begin : g_split
      logic [LO_W:0]   lo_sum_c;
      logic [LO_W-1:0] lo_q;
      logic            carry_q;
      logic [HI_W-1:0] a_hi_q;
      logic [HI_W-1:0] b_hi_q;
      logic [HI_W-1:0] hi_sum_c;

      assign lo_sum_c = {1'b0, a[LO_W-1:0]} + {1'b0, b[LO_W-1:0]};

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          lo_q    <= '0;
          carry_q <= 1'b0;
          a_hi_q  <= '0;
          b_hi_q  <= '0;
        end else begin
          lo_q    <= lo_sum_c[LO_W-1:0];
          carry_q <= lo_sum_c[LO_W];
          a_hi_q  <= a[OUT_W-1:LO_W];
          b_hi_q  <= b[OUT_W-1:LO_W];
        end
      end

      assign hi_sum_c     = a_hi_q + b_hi_q + HI_W'(carry_q);
      assign mid_words[k] = {hi_sum_c, lo_q};
    end else begin : g_comb
      assign mid_words[k] = a + b;
    end
  end

  // Unpaired last word passes through with the same stage count as the sums
  if (NUM_IN_WORDS % 2 == 1) begin : g_odd
    if (REGISTER_MIDDLE) begin : g_odd_reg
      logic [OUT_W-1:0] odd_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) odd_q <= '0;
        else     odd_q <= ext_words[NUM_IN_WORDS-1];
      end
      assign mid_words[NUM_OUT_WORDS-1] = odd_q;
    end else begin : g_odd_comb
      assign mid_words[NUM_OUT_WORDS-1] = ext_words[NUM_IN_WORDS-1];
    end
  end

  if (REGISTER_MIDDLE) begin : g_mid_extra
    logic extra_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) extra_q <= 1'b0;
      else     extra_q <= extra_src;
    end
    assign mid_extra = extra_q;
  end else begin : g_mid_extra_comb
    assign mid_extra = extra_src;
  end

  // Optional output register for the words and the side-band bit
  if (REGISTER_OUTPUT) begin : g_out_reg
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned i = 0; i < NUM_OUT_WORDS; i++) words_out[i] <= '0;
        extra_bit_out <= 1'b0;
      end else begin
        for (int unsigned i = 0; i < NUM_OUT_WORDS; i++) words_out[i] <= mid_words[i];
        extra_bit_out <= mid_extra;
      end
    end
  end else begin : g_out_comb
    assign words_out     = mid_words;
    assign extra_bit_out = mid_extra;
  end

endmodule

// File: tb/tb_int_adder_tree_layer.sv
// Bench for int_adder_tree_layer: several parameterisations share one stimulus
// stream and are compared against an arithmetic history-based reference.
module tb_int_adder_tree_layer;

  localparam int MAXC = 1024;

  logic       clk = 1'b0;
  logic       rst;
  logic       extra_in;
  logic [7:0] stim [5];
  logic [7:0] in4  [4];
  logic [7:0] in3  [3];

  logic [8:0]  a_out [2], b_out [2], c_out [2], d_out [2], e_out [2], f_out [2], g_out [2];
  logic [11:0] i_out [3];
  logic        xa, xb, xc, xd, xe, xf, xg, xi;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;

  logic [7:0] hist_w [MAXC][5];
  logic       hist_x [MAXC];
  logic       hist_r [MAXC];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < 4; i++) in4[i] = stim[i];
    for (int i = 0; i < 3; i++) in3[i] = stim[i];
  end

  int_adder_tree_layer #(.NUM_IN_WORDS(4), .BITS_PER_IN_WORD(8), .BITS_PER_OUT_WORD(9), .SIGN_EXT(1'b1),
    .REGISTER_MIDDLE(1'b0), .REGISTER_OUTPUT(1'b0), .EXTRA_BIT_CONNECTED(1'b1)) u_a (
    .clk(clk), .rst(rst), .words_in(in4), .words_out(a_out), .extra_bit_in(extra_in), .extra_bit_out(xa));
  int_adder_tree_layer #(.NUM_IN_WORDS(4), .BITS_PER_IN_WORD(8), .BITS_PER_OUT_WORD(9), .SIGN_EXT(1'b0),
    .REGISTER_MIDDLE(1'b0), .REGISTER_OUTPUT(1'b0), .EXTRA_BIT_CONNECTED(1'b0)) u_b (
    .clk(clk), .rst(rst), .words_in(in4), .words_out(b_out), .extra_bit_in(extra_in), .extra_bit_out(xb));
  int_adder_tree_layer #(.NUM_IN_WORDS(3), .BITS_PER_IN_WORD(8), .BITS_PER_OUT_WORD(9), .SIGN_EXT(1'b1),
    .REGISTER_MIDDLE(1'b0), .REGISTER_OUTPUT(1'b0), .EXTRA_BIT_CONNECTED(1'b0)) u_c (
    .clk(clk), .rst(rst), .words_in(in3), .words_out(c_out), .extra_bit_in(extra_in), .extra_bit_out(xc));
  int_adder_tree_layer #(.NUM_IN_WORDS(3), .BITS_PER_IN_WORD(8), .BITS_PER_OUT_WORD(9), .SIGN_EXT(1'b0),
    .REGISTER_MIDDLE(1'b1), .REGISTER_OUTPUT(1'b0), .EXTRA_BIT_CONNECTED(1'b1)) u_d (
    .clk(clk), .rst(rst), .words_in(in3), .words_out(d_out), .extra_bit_in(extra_in), .extra_bit_out(xd));
  int_adder_tree_layer #(.NUM_IN_WORDS(3), .BITS_PER_IN_WORD(8), .BITS_PER_OUT_WORD(9), .SIGN_EXT(1'b1),
    .REGISTER_MIDDLE(1'b0), .REGISTER_OUTPUT(1'b1), .EXTRA_BIT_CONNECTED(1'b1)) u_e (
    .clk(clk), .rst(rst), .words_in(in3), .words_out(e_out), .extra_bit_in(extra_in), .extra_bit_out(xe));
  int_adder_tree_layer #(.NUM_IN_WORDS(3), .BITS_PER_IN_WORD(8), .BITS_PER_OUT_WORD(9), .SIGN_EXT(1'b1),
    .REGISTER_MIDDLE(1'b1), .REGISTER_OUTPUT(1'b1), .EXTRA_BIT_CONNECTED(1'b0)) u_f (
    .clk(clk), .rst(rst), .words_in(in3), .words_out(f_out), .extra_bit_in(extra_in), .extra_bit_out(xf));
  int_adder_tree_layer #(.NUM_IN_WORDS(4), .BITS_PER_IN_WORD(8), .BITS_PER_OUT_WORD(9), .SIGN_EXT(1'b0),
    .REGISTER_MIDDLE(1'b1), .REGISTER_OUTPUT(1'b1), .EXTRA_BIT_CONNECTED(1'b1)) u_g (
    .clk(clk), .rst(rst), .words_in(in4), .words_out(g_out), .extra_bit_in(extra_in), .extra_bit_out(xg));
  int_adder_tree_layer #(.NUM_IN_WORDS(5), .BITS_PER_IN_WORD(8), .BITS_PER_OUT_WORD(12), .SIGN_EXT(1'b1),
    .REGISTER_MIDDLE(1'b1), .REGISTER_OUTPUT(1'b0), .EXTRA_BIT_CONNECTED(1'b1)) u_i (
    .clk(clk), .rst(rst), .words_in(stim), .words_out(i_out), .extra_bit_in(extra_in), .extra_bit_out(xi));

  task automatic chk(input string nm, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic int ext8(input logic [7:0] w, input bit sgn);
    return (sgn && w[7]) ? int'(w) - 256 : int'(w);
  endfunction

  // Reference: pair sum of the inputs seen `lat` cycles ago, modulo 2^ow
  function automatic int model_word(input int src, input int n, input int k, input bit sgn, input int ow);
    int s;
    s = ext8(hist_w[src][2*k], sgn);
    if (2*k + 1 < n) s += ext8(hist_w[src][2*k+1], sgn);
    return s & ((1 << ow) - 1);
  endfunction

  task automatic check_inst(input string nm, input int lat, input int n, input bit sgn, input int ow,
                            input bit conn, input int act[3], input logic act_x);
    bit valid;
    int src;
    valid = 1'b1;
    src   = cyc - lat;
    if (lat > 0)
      for (int d = 0; d <= lat; d++)
        if (cyc - d < 0 || hist_r[cyc-d]) valid = 1'b0;
    for (int k = 0; k < (n + 1) / 2; k++)
      chk($sformatf("%s.word%0d", nm, k), act[k], valid ? model_word(src, n, k, sgn, ow) : 0);
    chk($sformatf("%s.extra", nm), int'(act_x), (valid && conn) ? int'(hist_x[src]) : 0);
  endtask

  // Every cycle, record the applied inputs and check all instances against the model
  always @(negedge clk) begin
    int act[3];
    if (cyc < MAXC) begin
      for (int i = 0; i < 5; i++) hist_w[cyc][i] = stim[i];
      hist_x[cyc] = extra_in;
      hist_r[cyc] = rst;
      act[2] = 0;
      act[0] = int'(a_out[0]); act[1] = int'(a_out[1]); check_inst("A", 0, 4, 1'b1, 9, 1'b1, act, xa);
      act[0] = int'(b_out[0]); act[1] = int'(b_out[1]); check_inst("B", 0, 4, 1'b0, 9, 1'b0, act, xb);
      act[0] = int'(c_out[0]); act[1] = int'(c_out[1]); check_inst("C", 0, 3, 1'b1, 9, 1'b0, act, xc);
      act[0] = int'(d_out[0]); act[1] = int'(d_out[1]); check_inst("D", 1, 3, 1'b0, 9, 1'b1, act, xd);
      act[0] = int'(e_out[0]); act[1] = int'(e_out[1]); check_inst("E", 1, 3, 1'b1, 9, 1'b1, act, xe);
      act[0] = int'(f_out[0]); act[1] = int'(f_out[1]); check_inst("F", 2, 3, 1'b1, 9, 1'b0, act, xf);
      act[0] = int'(g_out[0]); act[1] = int'(g_out[1]); check_inst("G", 2, 4, 1'b0, 9, 1'b1, act, xg);
      act[0] = int'(i_out[0]); act[1] = int'(i_out[1]); act[2] = int'(i_out[2]);
      check_inst("I", 1, 5, 1'b1, 12, 1'b1, act, xi);
    end
  end

  typedef struct packed {
    logic [3:0][7:0] w;
    logic [1:0][8:0] es;
    logic [1:0][8:0] eu;
    logic [8:0]      eo;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] w0, w1, w2, w3,
                              input logic [8:0] es0, es1, eu0, eu1, eo);
    vec_t v;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.es[0] = es0; v.es[1] = es1; v.eu[0] = eu0; v.eu[1] = eu1; v.eo = eo;
    return v;
  endfunction

  task automatic set_stim(input logic [7:0] w0, w1, w2, w3, w4);
    stim[0] = w0; stim[1] = w1; stim[2] = w2; stim[3] = w3; stim[4] = w4;
  endtask

  vec_t tbl [5];

  initial begin
    tbl[0] = mk(8'h7F, 8'h7F, 8'h80, 8'hFF, 9'h0FE, 9'h17F, 9'h0FE, 9'h17F, 9'h180);
    tbl[1] = mk(8'hFF, 8'hFF, 8'h80, 8'hFF, 9'h1FE, 9'h17F, 9'h1FE, 9'h17F, 9'h180);
    tbl[2] = mk(8'h00, 8'h00, 8'h00, 8'h00, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000);
    tbl[3] = mk(8'h80, 8'h80, 8'h7F, 8'h01, 9'h100, 9'h080, 9'h100, 9'h080, 9'h07F);
    tbl[4] = mk(8'h01, 8'hFF, 8'hFE, 8'h03, 9'h000, 9'h001, 9'h100, 9'h101, 9'h1FE);

    rst = 1'b1;
    extra_in = 1'b0;
    set_stim(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    chk("reset.g0", int'(g_out[0]), 0);
    chk("reset.gx", int'(xg), 0);
    chk("reset.f1", int'(f_out[1]), 0);
    chk("reset.i2", int'(i_out[2]), 0);
    rst = 1'b0;

    // Directed vectors on the combinational instances
    for (int r = 0; r < 5; r++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) stim[i] = tbl[r].w[i];
      stim[4]  = 8'($urandom);
      extra_in = 1'($urandom);
      #2;
      chk($sformatf("tbl%0d.sgn0", r), int'(a_out[0]), int'(tbl[r].es[0]));
      chk($sformatf("tbl%0d.sgn1", r), int'(a_out[1]), int'(tbl[r].es[1]));
      chk($sformatf("tbl%0d.uns0", r), int'(b_out[0]), int'(tbl[r].eu[0]));
      chk($sformatf("tbl%0d.uns1", r), int'(b_out[1]), int'(tbl[r].eu[1]));
      chk($sformatf("tbl%0d.odd0", r), int'(c_out[0]), int'(tbl[r].es[0]));
      chk($sformatf("tbl%0d.odd1", r), int'(c_out[1]), int'(tbl[r].eo));
      chk($sformatf("tbl%0d.xa", r), int'(xa), int'(extra_in));
    end

    // Carry split, odd-word alignment and extra-bit pulse across latencies
    @(posedge clk); #1; set_stim(8'h0F, 8'h01, 8'h80, 8'h00, 8'h00); extra_in = 1'b1;
    @(posedge clk); #1; set_stim(8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00); extra_in = 1'b0;
    #2;
    chk("seq.d0", int'(d_out[0]), 'h010);
    chk("seq.d1", int'(d_out[1]), 'h080);
    chk("seq.dx", int'(xd), 1);
    chk("seq.e0", int'(e_out[0]), 'h010);
    chk("seq.e1", int'(e_out[1]), 'h180);
    @(posedge clk); #1; set_stim(8'h80, 8'h7F, 8'h01, 8'hFF, 8'h00);
    #2;
    chk("seq.g0", int'(g_out[0]), 'h010);
    chk("seq.g1", int'(g_out[1]), 'h080);
    chk("seq.gx", int'(xg), 1);
    chk("seq.f0", int'(f_out[0]), 'h010);
    chk("seq.f1", int'(f_out[1]), 'h180);
    chk("seq.fx", int'(xf), 0);
    @(posedge clk); #1; set_stim(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    #2;
    chk("seq.g0b", int'(g_out[0]), 'h1FE);
    chk("seq.g1b", int'(g_out[1]), 'h000);
    chk("seq.gxb", int'(xg), 0);
    @(posedge clk); #1;
    #2;
    chk("seq.g0c", int'(g_out[0]), 'h0FF);
    chk("seq.g1c", int'(g_out[1]), 'h100);

    // Asynchronous reset with data in flight
    @(posedge clk); #1; set_stim(8'h11, 8'h22, 8'h33, 8'h44, 8'h55); extra_in = 1'b1;
    @(posedge clk); #1; set_stim(8'h12, 8'h34, 8'h56, 8'h78, 8'h9A);
    #1; rst = 1'b1;
    #1;
    chk("rst.g0", int'(g_out[0]), 0);
    chk("rst.g1", int'(g_out[1]), 0);
    chk("rst.gx", int'(xg), 0);
    chk("rst.d0", int'(d_out[0]), 0);
    chk("rst.e1", int'(e_out[1]), 0);
    chk("rst.i0", int'(i_out[0]), 0);
    @(posedge clk); #1; set_stim(8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE);
    @(posedge clk); #1; rst = 1'b0; set_stim(8'h03, 8'h04, 8'h05, 8'h06, 8'h00); extra_in = 1'b1;
    #2;
    chk("rel0.g0", int'(g_out[0]), 0);
    chk("rel0.gx", int'(xg), 0);
    @(posedge clk); #1; set_stim(8'h00, 8'h00, 8'h00, 8'h00, 8'h00); extra_in = 1'b0;
    #2;
    chk("rel1.g0", int'(g_out[0]), 0);
    chk("rel1.gx", int'(xg), 0);
    @(posedge clk); #1; set_stim(8'h09, 8'h08, 8'h07, 8'h06, 8'h05);
    #2;
    chk("rel2.g0", int'(g_out[0]), 'h007);
    chk("rel2.g1", int'(g_out[1]), 'h00B);
    chk("rel2.gx", int'(xg), 1);

    // Random stream with occasional mid-cycle resets
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) stim[i] = 8'($urandom);
      extra_in = 1'($urandom);
      if ($urandom_range(39, 0) == 0) begin
        #2 rst = 1'b1;
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
